// File: rtl/palette_fade_ctrl.sv
// Palette brightness fader: steps a 4-bit level between full and black on frame ticks
// and scales the incoming RGB by level/15. Optional flash feature: PALETTE_FADE_FLASH_EN.
module palette_fade_ctrl #(
  parameter int unsigned FRAMES_PER_STEP = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       fade_out_req,
  input  logic       fade_in_req,
`ifdef PALETTE_FADE_FLASH_EN
  input  logic       flash_req,
`endif
  input  logic [3:0] red_in,
  input  logic [3:0] green_in,
  input  logic [3:0] blue_in,
  output logic [3:0] red_out,
  output logic [3:0] green_out,
  output logic [3:0] blue_out,
  output logic [3:0] level,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    StBright  = 2'd0,
    StFadeOut = 2'd1,
    StDark    = 2'd2,
    StFadeIn  = 2'd3
  } state_e;

  localparam logic [3:0] StepCount = 4'(FRAMES_PER_STEP);

  state_e     state_q, state_d;
  logic [3:0] level_q, level_d;
  logic [3:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic [3:0] red_q, green_q, blue_q;
  logic [3:0] red_d, green_d, blue_d;
  logic [3:0] cnt_inc;
  logic       step_hit;

  // Rounded scale: (c * l + 7) / 15, product fits in 8 bits (max 232).
  function automatic logic [3:0] scale(input logic [3:0] c, input logic [3:0] l);
    logic [7:0] p;
    logic [7:0] q;
    p = ({4'd0, c} * {4'd0, l}) + 8'd7;
    q = p / 8'd15;
    return q[3:0];
  endfunction

  assign cnt_inc  = cnt_q + 4'd1;
  assign step_hit = frame_tick && (cnt_inc == StepCount);

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StBright: begin
        level_d = 4'd15;
        if (fade_out_req) begin
          state_d = StFadeOut;
          cnt_d   = 4'd0;
        end
      end
      StFadeOut: begin
        if (step_hit) begin
          cnt_d = 4'd0;
          if (level_q != 4'd0) level_d = level_q - 4'd1;
          if (level_q <= 4'd1) begin
            state_d = StDark;
            done_d  = 1'b1;
          end
        end else if (frame_tick) begin
          cnt_d = cnt_inc;
        end
      end
      StDark: begin
        level_d = 4'd0;
        // fade_out_req has priority, and is itself meaningless here
        if (fade_in_req && !fade_out_req) begin
          state_d = StFadeIn;
          cnt_d   = 4'd0;
        end
      end
      StFadeIn: begin
        if (step_hit) begin
          cnt_d = 4'd0;
          if (level_q != 4'd15) level_d = level_q + 4'd1;
          if (level_q >= 4'd14) begin
            state_d = StBright;
            done_d  = 1'b1;
          end
        end else if (frame_tick) begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = StBright;
        level_d = 4'd15;
        cnt_d   = 4'd0;
      end
    endcase
  end

`ifdef PALETTE_FADE_FLASH_EN
  logic [2:0] flash_q, flash_d;

  always_comb begin
    flash_d = flash_q;
    if (state_q != StBright) begin
      flash_d = 3'd0;
    end else if (fade_out_req) begin
      flash_d = 3'd0;
    end else if (flash_req) begin
      flash_d = 3'd4;
    end else if (frame_tick && (flash_q != 3'd0)) begin
      flash_d = flash_q - 3'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) flash_q <= 3'd0;
    else          flash_q <= flash_d;
  end

  always_comb begin
    red_d   = scale(red_in, level_q);
    green_d = scale(green_in, level_q);
    blue_d  = scale(blue_in, level_q);
    if (flash_q != 3'd0) begin
      red_d   = 4'hF;
      green_d = 4'hF;
      blue_d  = 4'hF;
    end
  end
`else
  always_comb begin
    red_d   = scale(red_in, level_q);
    green_d = scale(green_in, level_q);
    blue_d  = scale(blue_in, level_q);
  end
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StBright;
      level_q <= 4'd15;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
      red_q   <= 4'd0;
      green_q <= 4'd0;
      blue_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign red_out   = red_q;
  assign green_out = green_q;
  assign blue_out  = blue_q;
  assign level     = level_q;
  assign busy      = (state_q == StFadeOut) || (state_q == StFadeIn);
  assign done      = done_q;

endmodule

// File: tb/tb_palette_fade_ctrl.sv
// Directed bench for palette_fade_ctrl with FRAMES_PER_STEP = 2.
module tb_palette_fade_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       fade_out_req = 1'b0;
  logic       fade_in_req = 1'b0;
`ifdef PALETTE_FADE_FLASH_EN
  logic       flash_req = 1'b0;
`endif
  logic [3:0] red_in = 4'd0;
  logic [3:0] green_in = 4'd0;
  logic [3:0] blue_in = 4'd0;
  logic [3:0] red_out, green_out, blue_out, level;
  logic       busy, done;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;

  palette_fade_ctrl #(.FRAMES_PER_STEP(2)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_tick  (frame_tick),
    .fade_out_req(fade_out_req),
    .fade_in_req (fade_in_req),
`ifdef PALETTE_FADE_FLASH_EN
    .flash_req   (flash_req),
`endif
    .red_in      (red_in),
    .green_in    (green_in),
    .blue_in     (blue_in),
    .red_out     (red_out),
    .green_out   (green_out),
    .blue_out    (blue_out),
    .level       (level),
    .busy        (busy),
    .done        (done)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (done) done_cnt++;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
  endtask

  function automatic logic [15:0] rgb();
    return {4'd0, red_out, green_out, blue_out};
  endfunction

  initial begin
    // Reset state
    cyc();
    cyc();
    check_eq("rst_level", 16'(level), 16'd15);
    check_eq("rst_rgb", rgb(), 16'h000);
    check_eq("rst_busy", 16'(busy), 16'd0);
    check_eq("rst_done", 16'(done), 16'd0);

    // Passthrough at full brightness
    Reset_n = 1'b1;
    red_in = 4'hA; green_in = 4'h5; blue_in = 4'h0;
    cyc();
    check_eq("pass_rgb", rgb(), 16'hA50);
    check_eq("pass_level", 16'(level), 16'd15);
    check_eq("pass_busy", 16'(busy), 16'd0);

    // Fade out; the coincident frame_tick must not count
    red_in = 4'hF; green_in = 4'h7; blue_in = 4'h1;
    fade_out_req = 1'b1; frame_tick = 1'b1;
    cyc();
    fade_out_req = 1'b0; frame_tick = 1'b0;
    cyc();
    check_eq("fo_busy", 16'(busy), 16'd1);
    check_eq("fo_level0", 16'(level), 16'd15);
    for (int k = 1; k <= 30; k++) begin
      tick();
      check_eq($sformatf("fo_level_t%0d", k), 16'(level), 16'(15 - k / 2));
      if (k == 14) check_eq("lvl8_rgb", rgb(), 16'h841);
      if (k == 10) begin
        fade_in_req = 1'b1;
        cyc();
        fade_in_req = 1'b0;
        check_eq("fo_no_reverse", 16'(busy), 16'd1);
      end
    end
    check_eq("fo_done_cnt", 16'(done_cnt), 16'd1);
    check_eq("dark_busy", 16'(busy), 16'd0);
    check_eq("dark_rgb", rgb(), 16'h000);

    // Both requests in DARK are ignored
    fade_in_req = 1'b1; fade_out_req = 1'b1;
    cyc();
    fade_in_req = 1'b0; fade_out_req = 1'b0;
    cyc();
    check_eq("both_busy", 16'(busy), 16'd0);
    tick();
    tick();
    tick();
    check_eq("both_level", 16'(level), 16'd0);

    // Fade in
    fade_in_req = 1'b1;
    cyc();
    fade_in_req = 1'b0;
    check_eq("fi_busy", 16'(busy), 16'd1);
    for (int k = 1; k <= 30; k++) begin
      tick();
      check_eq($sformatf("fi_level_t%0d", k), 16'(level), 16'(k / 2));
    end
    check_eq("fi_done_cnt", 16'(done_cnt), 16'd2);
    check_eq("bright_busy", 16'(busy), 16'd0);
    check_eq("bright_rgb", rgb(), 16'hF71);
    tick();
    tick();
    check_eq("bright_hold", 16'(level), 16'd15);

    // fade_in_req in BRIGHT is ignored
    fade_in_req = 1'b1;
    cyc();
    fade_in_req = 1'b0;
    check_eq("bright_fi_ign", 16'(busy), 16'd0);

    // Reset mid fade-out at level 6
    fade_out_req = 1'b1;
    cyc();
    fade_out_req = 1'b0;
    for (int k = 1; k <= 18; k++) tick();
    check_eq("mid_level", 16'(level), 16'd6);
    Reset_n = 1'b0;
    #1;
    check_eq("abort_level", 16'(level), 16'd15);
    check_eq("abort_busy", 16'(busy), 16'd0);
    check_eq("abort_rgb", rgb(), 16'h000);
    cyc();
    cyc();
    Reset_n = 1'b1;
    cyc();
    cyc();
    check_eq("abort_done_cnt", 16'(done_cnt), 16'd2);
    check_eq("post_rst_rgb", rgb(), 16'hF71);

`ifdef PALETTE_FADE_FLASH_EN
    red_in = 4'h3; green_in = 4'h2; blue_in = 4'h1;
    flash_req = 1'b1;
    cyc();
    flash_req = 1'b0;
    cyc();
    check_eq("flash_rgb0", rgb(), 16'hFFF);
    check_eq("flash_busy", 16'(busy), 16'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq($sformatf("flash_rgb_t%0d", k), rgb(), 16'hFFF);
    end
    tick();
    cyc();
    check_eq("flash_end_rgb", rgb(), 16'h321);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/palette_fade_ctrl.md
PALETTE_FADE_CTRL -- requirements
Module: palette_fade_ctrl

Interface
REQ-001 SHALL have parameter FRAMES_PER_STEP, default 2: number of frame_tick pulses per brightness step, legal 1..15.
REQ-002 SHALL have port Clk, input, 1: single system/pixel clock; all logic on its rising edge.
REQ-003 SHALL have port Reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port frame_tick, input, 1: one-cycle pulse per video frame.
REQ-005 SHALL have port fade_out_req, input, 1: one-cycle pulse requesting a fade to black.
REQ-006 SHALL have port fade_in_req, input, 1: one-cycle pulse requesting a fade to full brightness.
REQ-007 SHALL have ports red_in, green_in, blue_in, input, 4 each: raw palette colour for the current pixel.
REQ-008 SHALL have ports red_out, green_out, blue_out, output, 4 each: scaled colour, registered.
REQ-009 SHALL have port level, output, 4: current brightness, 15 = full, 0 = black.
REQ-010 SHALL have port busy, output, 1: high in FADE_OUT and FADE_IN.
REQ-011 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-012 SHALL implement states BRIGHT, FADE_OUT, DARK, FADE_IN.
REQ-013 BRIGHT + fade_out_req -> FADE_OUT next cycle. DARK + fade_in_req -> FADE_IN next cycle.
REQ-014 Requests arriving in any other state or pairing SHALL be ignored, with no queuing and no mid-fade reversal.
REQ-015 If fade_out_req and fade_in_req are high in the same cycle, fade_out_req SHALL take priority; in DARK that means both are ignored.
REQ-016 A 4-bit frame counter SHALL clear on entry to a fading state and increment on each frame_tick while fading.
REQ-017 When the frame counter reaches FRAMES_PER_STEP, it SHALL clear and level SHALL step by one: -1 in FADE_OUT, +1 in FADE_IN.
REQ-018 FADE_OUT SHALL go to DARK on the cycle level becomes 0; FADE_IN SHALL go to BRIGHT on the cycle level becomes 15.
REQ-019 done SHALL pulse on that same transition cycle and SHALL pulse at no other time.
REQ-020 level SHALL saturate, never wrapping below 0 or above 15.
REQ-021 In BRIGHT level SHALL hold at 15; in DARK it SHALL hold at 0.
REQ-022 Each output channel SHALL equal (c_in*level + 7) / 15, using integer division of an 8-bit product.
REQ-023 That result SHALL be registered: 1-cycle latency from c_in and level to c_out.
REQ-024 Consequences of REQ-022: level 15 passes the input through unchanged, and level 0 gives 0.
REQ-025 A full fade SHALL take exactly 15*FRAMES_PER_STEP frame_ticks.
REQ-026 frame_tick in the same cycle as a request SHALL NOT count toward the first step.

Reset
REQ-027 While Reset_n is low, state SHALL be BRIGHT, level 15, frame counter 0, red_out/green_out/blue_out 0, busy 0, done 0.
REQ-028 Reset asserted mid-fade SHALL abort the fade immediately, with no done pulse.
REQ-029 After release, the first registered output SHALL appear on the first rising Clk edge.

Configuration
REQ-030 Macro PALETTE_FADE_FLASH_EN: when defined, SHALL add input flash_req (1 bit) and a flash counter.
REQ-031 With the macro, flash_req in BRIGHT SHALL force all outputs to 4'hF for the next 4 frame_ticks; busy stays 0.
REQ-032 With the macro, flash_req in any other state SHALL be ignored.
REQ-033 With the macro, a fade_out_req arriving during a flash SHALL cancel the flash and start FADE_OUT.
REQ-034 Without the macro, the flash_req port and flash logic SHALL be absent and behaviour SHALL be as above.

Verification
REQ-035 Reset release, then rgb_in=A,5,0 -> next cycle rgb_out=A,5,0, level=15, busy=0.
REQ-036 FRAMES_PER_STEP=2, fade_out_req, then 30 frame_ticks -> level drops by 1 every 2 ticks; done pulses once on tick 30; state DARK; rgb_out=0,0,0.
REQ-037 In DARK, fade_in_req and fade_out_req in the same cycle -> both ignored, level stays 0; a later fade_in_req alone -> level reaches 15 after 30 ticks.
REQ-038 At level 8 with rgb_in=F,7,1 -> rgb_out=8,4,1, i.e. (15*8+7)/15=8, (7*8+7)/15=4, (1*8+7)/15=1.
REQ-039 Reset_n low at level 6 mid FADE_OUT -> level 15, busy 0, no done pulse.
REQ-040 With PALETTE_FADE_FLASH_EN defined, flash_req in BRIGHT -> rgb_out=F,F,F for 4 frame_ticks, then passthrough resumes.
